// File: rtl/mux_arb_reg_if.sv
// Handshake bundle for mux_arb_reg: CH valid/ready input streams, one registered output stream.
// o_chid is present only when MUX_ARB_CHID_EN is defined.
interface mux_arb_reg_if #(
  parameter int WIDTH = 32,
  parameter int CH    = 4
);
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;

  logic                  i_mode;
  logic [CH-1:0]         i_valid;
  logic [CH-1:0]         o_ready;
  logic [CH*WIDTH-1:0]   i_data;
  logic                  o_valid;
  logic                  i_ready;
  logic [WIDTH-1:0]      o_data;
`ifdef MUX_ARB_CHID_EN
  logic [CW-1:0]         o_chid;
`endif

  modport master (
    output i_mode, i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data
`ifdef MUX_ARB_CHID_EN
    , input o_chid
`endif
  );

  modport slave (
    input  i_mode, i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data
`ifdef MUX_ARB_CHID_EN
    , output o_chid
`endif
  );
endinterface

// File: rtl/mux_arb_reg.sv
// Registered CH-channel arbitrating mux: round-robin (i_mode=0) or fixed lowest-index priority (i_mode=1).
// Optional macro MUX_ARB_CHID_EN adds the o_chid source-channel register.
module mux_arb_reg #(
  parameter int WIDTH = 32,
  parameter int CH    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  mux_arb_reg_if.slave  bus
);
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;

  logic [CW-1:0]    ptr_p0;
  logic             vld_p0;
  logic [WIDTH-1:0] data_p0;
`ifdef MUX_ARB_CHID_EN
  logic [CW-1:0]    chid_p0;
`endif

  logic             load;
  logic             hit;
  logic [CW-1:0]    start;
  logic [CW-1:0]    cand;
  logic [CW-1:0]    sel;
  logic [CW-1:0]    ptr_nxt;
  logic [CH-1:0]    grant;
  logic [WIDTH-1:0] data_sel;
  int               idx;

  assign load  = !vld_p0 || bus.i_ready;
  // Fixed priority is a rotating search that always starts at channel 0.
  assign start = bus.i_mode ? '0 : ptr_p0;

  always_comb begin
    hit  = 1'b0;
    sel  = '0;
    cand = '0;
    idx  = 0;
    for (int k = 0; k < CH; k++) begin
      idx = int'(start) + k;
      if (idx >= CH) idx = idx - CH;
      cand = CW'(idx);
      if (!hit && bus.i_valid[cand]) begin
        hit = 1'b1;
        sel = cand;
      end
    end
  end

  assign grant       = hit ? (CH'(1) << sel) : '0;
  assign bus.o_ready = (load && !i_rst) ? grant : '0;
  assign data_sel    = bus.i_data[int'(sel)*WIDTH +: WIDTH];
  assign ptr_nxt     = (sel == CW'(CH-1)) ? '0 : sel + 1'b1;

  // Stage p0: output register and round-robin pointer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      ptr_p0  <= '0;
`ifdef MUX_ARB_CHID_EN
      chid_p0 <= '0;
`endif
    end else if (load) begin
      vld_p0 <= hit;
      if (hit) begin
        data_p0 <= data_sel;
        ptr_p0  <= ptr_nxt;
`ifdef MUX_ARB_CHID_EN
        chid_p0 <= sel;
`endif
      end
    end
  end

  assign bus.o_valid = vld_p0;
  assign bus.o_data  = data_p0;
`ifdef MUX_ARB_CHID_EN
  assign bus.o_chid  = chid_p0;
`endif
endmodule
